// File: rtl/dram_responder_model_pkg.sv
// Shared cache-interface types plus responder constants.
// Request/response bundles used between the L2 and memory side.
package dram_responder_model_pkg;

  localparam int CACHE_WIDTH      = 128;
  localparam int RESP_LATENCY_MAX = 32;

  typedef struct packed {
    logic [26:0]            addr;
    logic [CACHE_WIDTH-1:0] data;
    logic                   rw;
    logic                   valid;
  } L2_req_type;

  typedef struct packed {
    logic [CACHE_WIDTH-1:0] data;
    logic                   ready;
  } mem_data_type;

endpackage

// File: rtl/dram_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
// Pointers wrap modulo DEPTH; the count separates full from empty.
module dram_rsp_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Occupancy follows push/pop; simultaneous push and pop cancel.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/dram_responder_model.sv
// Block-RAM memory responder for the cache request interface.
// Optional random request stalls: DRAM_RESPONDER_STALL_EN.
module dram_responder_model
  import dram_responder_model_pkg::*;
#(
  parameter int CACHE_WIDTH = dram_responder_model_pkg::CACHE_WIDTH,
  parameter int DEPTH_LOG2  = 12,
  parameter int ADDR_LSB    = 4,
  parameter int LATENCY     = 8,
  parameter int RSP_DEPTH   = 4
) (
  input  logic         sys_clk,
  input  logic         RST,
  input  L2_req_type   mem_req,
  output logic         req_rdy,
  output mem_data_type mem_data,
  input  logic         rsp_rdy
);

  localparam int LINES = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(RSP_DEPTH) + 1;
  localparam int NST   = (LATENCY > 1) ? LATENCY - 1 : 1;

  logic [CACHE_WIDTH-1:0] ram_q [LINES];
  logic [DEPTH_LOG2-1:0]  idx;
  logic                   acc, wr_acc, rd_acc;
  logic                   push, pop, stall;
  logic [CACHE_WIDTH-1:0] push_data, head, last_q;
  logic [CW-1:0]          fifo_cnt;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   run_q;
  logic                   unused_addr;

  assign idx         = mem_req.addr[ADDR_LSB +: DEPTH_LOG2];
  assign unused_addr = ^mem_req.addr;
  assign acc         = mem_req.valid && req_rdy;
  assign wr_acc      = acc && mem_req.rw;
  assign rd_acc      = acc && !mem_req.rw;

  assign req_rdy = run_q && (cnt_q < CW'(RSP_DEPTH)) && !stall;

`ifdef DRAM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q;
  logic        fb;
  assign fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign stall = (lfsr_q[1:0] == 2'b00);

  // Free-running Fibonacci LFSR driving random stalls.
  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], fb};
  end
`else
  assign stall = 1'b0;
`endif

  // Line storage; contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (wr_acc) ram_q[idx] <= mem_req.data;
  end

  if (LATENCY == 1) begin : g_direct
    assign push      = rd_acc;
    assign push_data = ram_q[idx];
  end else begin : g_delay
    logic [NST-1:0]         v_q;
    logic [CACHE_WIDTH-1:0] d_q [NST];

    // Valid bits of the read delay line.
    always_ff @(posedge sys_clk or posedge RST) begin
      if (RST) begin
        v_q <= '0;
      end else begin
        v_q[0] <= rd_acc;
        for (int i = 1; i < NST; i++) v_q[i] <= v_q[i-1];
      end
    end

    // RAM read register feeding the data delay line.
    always_ff @(posedge sys_clk) begin
      d_q[0] <= ram_q[idx];
      for (int i = 1; i < NST; i++) d_q[i] <= d_q[i-1];
    end

    assign push      = v_q[NST-1];
    assign push_data = d_q[NST-1];
  end

  dram_rsp_fifo #(
    .WIDTH (CACHE_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_i   (RST),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_cnt)
  );

  assign pop           = (fifo_cnt != '0) && rsp_rdy;
  assign mem_data.ready = pop;
  assign mem_data.data  = pop ? head : last_q;

  // Outstanding-read credits: accepted reads minus delivered responses.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({rd_acc, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Run flag, credit count and held response data.
  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      run_q <= 1'b1;
      cnt_q <= cnt_d;
      if (pop) last_q <= head;
    end
  end

endmodule

// File: tb/tb_dram_responder_model.sv
// Randomized scoreboard bench for dram_responder_model.
// Expected lines come from an array model of the spec rules.
module tb_dram_responder_model;
  import dram_responder_model_pkg::*;

  localparam int LAT = 8;
  localparam int CRD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rsp_rdy = 1'b1;
  L2_req_type   req;
  logic         req_rdy;
  mem_data_type md;

  always #5 clk = ~clk;

  dram_responder_model dut (
    .sys_clk  (clk),
    .RST      (rst),
    .mem_req  (req),
    .req_rdy  (req_rdy),
    .mem_data (md),
    .rsp_rdy  (rsp_rdy)
  );

  typedef struct {
    logic [127:0] d;
    int           due;
    bit           exact;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] mdl [int];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int stall_cyc = 0;
  bit chk_credit = 0;

  always @(posedge clk) cyc++;

  function automatic int line_of(input logic [26:0] a);
    return (int'(a) / 16) % 4096;
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every response pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && md.ready) begin
      pulses++;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_ready: pulse at cycle %0d, want none", cyc);
      end else begin
        e = sbq.pop_front();
        check("rsp_data", md.data, e.d);
        if (e.exact) check("rsp_cycle", 128'(cyc), 128'(e.due));
        else         check("rsp_not_early", 128'(cyc >= e.due), 128'(1));
      end
    end
  end

  // Credit rule against the count of reads still owed.
  always @(posedge clk) begin
    #2;
    if (chk_credit && !rst) begin
`ifdef DRAM_RESPONDER_STALL_EN
      if (!req_rdy && sbq.size() < CRD) stall_cyc++;
      if (req_rdy) check("credit_ok", 128'(sbq.size() < CRD), 128'(1));
`else
      check("credit_rule", 128'(req_rdy), 128'(sbq.size() < CRD));
`endif
    end
  end

  task automatic issue(input logic [26:0] a, input logic [127:0] d,
                       input bit rw, input bit exact);
    bit ok;
    ok = 0;
    req.addr  = a;
    req.data  = d;
    req.rw    = rw;
    req.valid = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (req_rdy) begin
        ok = 1;
        if (rw) mdl[line_of(a)] = d;
        else sbq.push_back('{mdl[line_of(a)], cyc + LAT, exact});
      end
      @(posedge clk);
      #1;
    end
    req.valid = 1'b0;
    req.data  = {4{$urandom}};
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: addr %h not accepted, want accept", a);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d left, want 0", sbq.size());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] P33 = {4{32'h33333333}};
  localparam logic [127:0] P1C = {4{32'h1C71C71C}};
  localparam logic [127:0] P0F = {4{32'h0F0F0F0F}};

  initial begin
    int p0;
    int hi;
    logic [26:0] a;
    req = '0;

    repeat (2) @(negedge clk);
    check("rst_req_rdy", 128'(req_rdy), 128'(0));
    check("rst_ready", 128'(md.ready), 128'(0));
    check("rst_data", md.data, 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rdy_after_rst", 128'(req_rdy), 128'(1));
    @(posedge clk);
    #1;

    issue(27'h100, P33, 1, 1);
    issue(27'h100, '0, 0, 1);
    drain();

    issue(27'h010, P33, 1, 1);
    issue(27'h020, P1C, 1, 1);
    issue(27'h030, P0F, 1, 1);
    issue(27'h010, '0, 0, 1);
    issue(27'h020, '0, 0, 1);
    issue(27'h030, '0, 0, 1);
    drain();

    p0 = pulses;
    issue(27'h050, {4{32'hA5A5_0005}}, 1, 1);
    idle(LAT + 4);
    check("write_no_pulse", 128'(pulses - p0), 128'(0));
    issue(27'h050, {4{32'h5A5A_1234}}, 1, 1);
    issue(27'h050, '0, 0, 1);
    drain();

    p0 = pulses;
    rsp_rdy = 1'b0;
    issue(27'h010, '0, 0, 0);
    issue(27'h020, '0, 0, 0);
    issue(27'h030, '0, 0, 0);
    issue(27'h100, '0, 0, 0);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_rdy) hi++;
    end
    check("full_blocks", 128'(hi), 128'(0));
    @(posedge clk);
    #1 rsp_rdy = 1'b1;
    issue(27'h050, '0, 0, 1);
    drain();
    check("hold_pulses", 128'(pulses - p0), 128'(5));

    issue(27'h010, '0, 0, 1);
    issue(27'h020, '0, 0, 1);
    issue(27'h030, '0, 0, 1);
    rst = 1'b1;
    sbq.delete();
    p0 = pulses;
    @(negedge clk);
    check("midrst_req_rdy", 128'(req_rdy), 128'(0));
    check("midrst_ready", 128'(md.ready), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rdy_after_midrst", 128'(req_rdy), 128'(1));
    @(posedge clk);
    #1;
    idle(LAT + 6);
    check("midrst_no_pulse", 128'(pulses - p0), 128'(0));
    issue(27'h100, '0, 0, 1);
    issue(27'h050, '0, 0, 1);
    drain();

    for (int l = 0; l < 16; l++) begin
      a = {11'($urandom), 12'(l), 4'($urandom)};
      issue(a, {$urandom, $urandom, $urandom, $urandom}, 1, 1);
    end
    chk_credit = 1;
    for (int n = 0; n < 200; n++) begin
      a = {11'($urandom), 12'($urandom_range(0, 15)), 4'($urandom)};
      issue(a, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 3) == 0, 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();
    chk_credit = 0;
`ifdef DRAM_RESPONDER_STALL_EN
    check("stalls_seen", 128'(stall_cyc > 0), 128'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
